// File: rtl/connect4_pkg.sv
// Shared encodings for the Connect-4 engine: cell/winner codes, FSM states
// and the per-axis unit steps walked by the win scanner.
package connect4_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_PLACE, S_CHECK, S_DONE} state_e;

    // Unit steps as 2-bit two's complement, indexed by axis: 0 H, 1 V, 2 diag, 3 anti-diag.
    localparam logic [3:0][1:0] AXIS_DR = {2'b01, 2'b01, 2'b01, 2'b00};
    localparam logic [3:0][1:0] AXIS_DC = {2'b11, 2'b01, 2'b00, 2'b01};

    function automatic logic signed [6:0] scale_step(input logic [1:0] d,
                                                     input logic signed [6:0] k);
        case (d)
            2'b01:   return k;
            2'b11:   return -k;
            default: return 7'sd0;
        endcase
    endfunction

endpackage

// File: rtl/connect4_win_scan.sv
// Sequential win walker: one candidate cell per cycle, each axis walked in the
// positive then negative direction from the placed cell.
module connect4_win_scan
    import connect4_pkg::*;
#(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4,
    localparam int RW = $clog2(ROWS),
    localparam int CW = $clog2(COLS),
    localparam int KW = $clog2(WIN_LEN + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clear_i,
    input  logic                            start_i,
    input  logic [ROWS-1:0][COLS-1:0][1:0]  board_i,
    input  logic [RW-1:0]                   row_i,
    input  logic [CW-1:0]                   col_i,
    input  logic [1:0]                      player_i,
    output logic                            done_o,
    output logic                            win_o
);

    // 7 signed bits hold row/col plus any offset up to 15 in either direction.
    localparam logic signed [6:0] ROWS_S = 7'(ROWS);
    localparam logic signed [6:0] COLS_S = 7'(COLS);

    logic [1:0]        axis_q, axis_d;
    logic              neg_q, neg_d;
    logic              active_q, active_d;
    logic [KW-1:0]     k_q, k_d, cnt_q, cnt_d;
    logic signed [6:0] koff, r_s, c_s;
    logic              in_bounds, match, last_k, dir_end, win;
    logic [1:0]        cand;

    always_comb begin
        koff      = neg_q ? -$signed(7'(k_q)) : $signed(7'(k_q));
        r_s       = $signed(7'(row_i)) + scale_step(AXIS_DR[axis_q], koff);
        c_s       = $signed(7'(col_i)) + scale_step(AXIS_DC[axis_q], koff);
        in_bounds = !r_s[6] && (r_s < ROWS_S) && !c_s[6] && (c_s < COLS_S);
        cand      = in_bounds ? board_i[r_s[RW-1:0]][c_s[CW-1:0]] : CELL_EMPTY;
        match     = active_q && in_bounds && (cand == player_i);
        last_k    = (k_q == KW'(WIN_LEN - 1));
        win       = match && (cnt_q + KW'(1) == KW'(WIN_LEN));
        dir_end   = !match || last_k;
        done_o    = active_q && (win || (dir_end && neg_q && axis_q == 2'd3));
        win_o     = win;
    end

    always_comb begin
        active_d = active_q;
        axis_d   = axis_q;
        neg_d    = neg_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            active_d = 1'b0;
        end else if (start_i) begin
            active_d = 1'b1;
            axis_d   = 2'd0;
            neg_d    = 1'b0;
            k_d      = KW'(1);
            cnt_d    = KW'(1);
        end else if (active_q) begin
            if (done_o) begin
                active_d = 1'b0;
            end else if (dir_end) begin
                k_d = KW'(1);
                if (!neg_q) begin
                    // Run length carries over into the opposite direction.
                    neg_d = 1'b1;
                    cnt_d = cnt_q + KW'(match);
                end else begin
                    neg_d  = 1'b0;
                    axis_d = axis_q + 2'd1;
                    cnt_d  = KW'(1);
                end
            end else begin
                k_d   = k_q + KW'(1);
                cnt_d = cnt_q + KW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            axis_q   <= 2'd0;
            neg_q    <= 1'b0;
            k_q      <= '0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            axis_q   <= axis_d;
            neg_q    <= neg_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/connect4_board_engine.sv
// Connect-4 engine: drop-edge handling, gravity placement, turn/status
// bookkeeping; the win walk is delegated to connect4_win_scan.
module connect4_board_engine
    import connect4_pkg::*;
#(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4,
    localparam int CW = $clog2(COLS),
    localparam int RW = $clog2(ROWS),
    localparam int HW = $clog2(ROWS + 1),
    localparam int MW = $clog2(ROWS * COLS + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [CW-1:0]            col_sel_i,
    input  logic                     drop_i,
    input  logic                     new_game_i,
    output logic [2*ROWS*COLS-1:0]   board_out_o,
    output logic                     turn_o,
    output logic                     busy_o,
    output logic                     invalid_o,
    output logic [1:0]               winner_o,
    output logic                     game_over_o,
    output logic [MW-1:0]            move_count_o
);

    localparam logic [CW:0] NCOL = COLS[CW:0];

    state_e                         state_q, state_d;
    logic [ROWS-1:0][COLS-1:0][1:0] board_q, board_d;
    logic [COLS-1:0][HW-1:0]        height_q, height_d;
    logic [MW-1:0]                  moves_q, moves_d;
    logic [RW-1:0]                  row_q, row_d;
    logic [CW-1:0]                  col_q, col_d;
    logic                           turn_q, turn_d;
    logic                           invalid_q, invalid_d;
    logic [1:0]                     winner_q, winner_d;
    logic                           drop_q;
    logic                           drop_edge, col_ok, scan_start, scan_done, scan_win;
    logic [1:0]                     player;

    assign drop_edge = drop_i & ~drop_q;
    assign col_ok    = {1'b0, col_sel_i} < NCOL;
    assign player    = turn_q ? CELL_P2 : CELL_P1;

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        height_d   = height_q;
        moves_d    = moves_q;
        row_d      = row_q;
        col_d      = col_q;
        turn_d     = turn_q;
        winner_d   = winner_q;
        invalid_d  = 1'b0;
        scan_start = 1'b0;
        case (state_q)
            S_IDLE: if (drop_edge) begin
                if (!col_ok || height_q[col_sel_i] == HW'(ROWS)) begin
                    invalid_d = 1'b1;
                end else begin
                    row_d   = height_q[col_sel_i][RW-1:0];
                    col_d   = col_sel_i;
                    state_d = S_PLACE;
                end
            end
            S_PLACE: begin
                board_d[row_q][col_q] = player;
                height_d[col_q]       = height_q[col_q] + HW'(1);
                moves_d               = moves_q + MW'(1);
                scan_start            = 1'b1;
                state_d               = S_CHECK;
            end
            S_CHECK: if (scan_done) begin
                if (scan_win) begin
                    winner_d = player;  // player cell codes double as winner codes
                    state_d  = S_DONE;
                end else if (moves_q == MW'(ROWS * COLS)) begin
                    winner_d = WIN_DRAW;
                    state_d  = S_DONE;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase
        if (new_game_i) begin
            state_d    = S_IDLE;
            board_d    = '0;
            height_d   = '0;
            moves_d    = '0;
            turn_d     = 1'b0;
            winner_d   = WIN_NONE;
            invalid_d  = 1'b0;
            scan_start = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            board_q   <= '0;
            height_q  <= '0;
            moves_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            turn_q    <= 1'b0;
            invalid_q <= 1'b0;
            winner_q  <= WIN_NONE;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            height_q  <= height_d;
            moves_q   <= moves_d;
            row_q     <= row_d;
            col_q     <= col_d;
            turn_q    <= turn_d;
            invalid_q <= invalid_d;
            winner_q  <= winner_d;
            drop_q    <= drop_i;
        end
    end

    connect4_win_scan #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .WIN_LEN (WIN_LEN)
    ) u_scan (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (new_game_i),
        .start_i  (scan_start),
        .board_i  (board_q),
        .row_i    (row_q),
        .col_i    (col_q),
        .player_i (player),
        .done_o   (scan_done),
        .win_o    (scan_win)
    );

    assign board_out_o  = board_q;
    assign turn_o       = turn_q;
    assign busy_o       = (state_q == S_PLACE) || (state_q == S_CHECK);
    assign invalid_o    = invalid_q;
    assign winner_o     = winner_q;
    assign game_over_o  = (winner_q != WIN_NONE);
    assign move_count_o = moves_q;

endmodule

// File: tb/tb_connect4_board_engine.sv
// Directed bench for connect4_board_engine on the default 6x7 board, WIN_LEN 4.
module tb_connect4_board_engine;

    localparam int ROWS    = 6;
    localparam int COLS    = 7;
    localparam int WIN_LEN = 4;
    localparam int CW      = $clog2(COLS);
    localparam int MW      = $clog2(ROWS * COLS + 1);

    localparam int G1[7]   = '{0, 1, 0, 1, 0, 1, 0};
    localparam int G2[8]   = '{0, 3, 0, 4, 0, 5, 1, 6};
    localparam int G4[11]  = '{4, 1, 1, 1, 6, 2, 1, 2, 2, 3, 3};
    localparam int PAIR[12] = '{0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1};

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [CW-1:0]          col_sel = '0;
    logic                   drop = 1'b0;
    logic                   new_game = 1'b0;
    logic [2*ROWS*COLS-1:0] board_out;
    logic                   turn, busy, invalid, game_over;
    logic [1:0]             winner;
    logic [MW-1:0]          move_count;

    int                     checks = 0;
    int                     errors = 0;
    logic [2*ROWS*COLS-1:0] exp_board;
    int                     hgt[COLS];
    int                     ply;
    logic                   inv;
    int                     bc;

    always #5 clk = ~clk;

    connect4_board_engine #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .col_sel_i    (col_sel),
        .drop_i       (drop),
        .new_game_i   (new_game),
        .board_out_o  (board_out),
        .turn_o       (turn),
        .busy_o       (busy),
        .invalid_o    (invalid),
        .winner_o     (winner),
        .game_over_o  (game_over),
        .move_count_o (move_count)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_board = '0;
        foreach (hgt[i]) hgt[i] = 0;
        ply = 0;
    endtask

    task automatic model_place(input int c);
        exp_board[2*(hgt[c]*COLS+c) +: 2] = (ply == 0) ? 2'b01 : 2'b10;
        hgt[c]++;
        ply ^= 1;
    endtask

    // One drop edge; returns invalid seen the cycle after the edge and busy cycle count.
    task automatic do_drop(input int c, output logic inv_o, output int bc_o);
        @(negedge clk);
        col_sel = CW'(c);
        drop = 1'b1;
        @(negedge clk);
        inv_o = invalid;
        drop = 1'b0;
        bc_o = 0;
        while (busy && bc_o < 100) begin
            bc_o++;
            @(negedge clk);
        end
        if (bc_o >= 100) chk("busy_timeout", 128'(bc_o), 128'(0));
    endtask

    task automatic play(input int c);
        do_drop(c, inv, bc);
        model_place(c);
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_board", 128'(board_out), 128'(0));
        chk("rst_turn", 128'(turn), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_invalid", 128'(invalid), 128'(0));
        chk("rst_winner", 128'(winner), 128'(0));
        chk("rst_over", 128'(game_over), 128'(0));
        chk("rst_moves", 128'(move_count), 128'(0));
        rst_n = 1'b1;

        // Vertical P1 win in column 0.
        play(G1[0]);
        chk("g1_m1_board", 128'(board_out), 128'(exp_board));
        chk("g1_m1_turn", 128'(turn), 128'(1));
        chk("g1_m1_busy", 128'(bc), 128'(9));
        chk("g1_m1_moves", 128'(move_count), 128'(1));
        for (int i = 1; i < 7; i++) play(G1[i]);
        chk("g1_busy", 128'(bc), 128'(7));
        chk("g1_winner", 128'(winner), 128'(1));
        chk("g1_over", 128'(game_over), 128'(1));
        chk("g1_moves", 128'(move_count), 128'(7));
        chk("g1_turn", 128'(turn), 128'(0));
        chk("g1_board", 128'(board_out), 128'(exp_board));
        do_drop(2, inv, bc);
        chk("g1_late_inv", 128'(inv), 128'(0));
        chk("g1_late_busy", 128'(bc), 128'(0));
        chk("g1_late_board", 128'(board_out), 128'(exp_board));

        // Horizontal P2 win across columns 3..6.
        pulse_new_game();
        chk("ng_board", 128'(board_out), 128'(0));
        chk("ng_winner", 128'(winner), 128'(0));
        for (int i = 0; i < 8; i++) play(G2[i]);
        chk("g2_winner", 128'(winner), 128'(2));
        chk("g2_moves", 128'(move_count), 128'(8));
        chk("g2_board", 128'(board_out), 128'(exp_board));
        do_drop(3, inv, bc);
        chk("g2_late_inv", 128'(inv), 128'(0));
        chk("g2_late_board", 128'(board_out), 128'(exp_board));

        // Full column and out-of-range column rejection.
        pulse_new_game();
        for (int i = 0; i < 6; i++) play(2);
        chk("g3_board", 128'(board_out), 128'(exp_board));
        do_drop(2, inv, bc);
        chk("g3_full_inv", 128'(inv), 128'(1));
        @(negedge clk);
        chk("g3_inv_pulse", 128'(invalid), 128'(0));
        chk("g3_turn", 128'(turn), 128'(0));
        chk("g3_moves", 128'(move_count), 128'(6));
        do_drop(7, inv, bc);
        chk("g3_col7_inv", 128'(inv), 128'(1));
        chk("g3_col7_board", 128'(board_out), 128'(exp_board));

        // Anti-diagonal P1 win completed at (1,3), a middle cell of the run.
        pulse_new_game();
        for (int i = 0; i < 11; i++) play(G4[i]);
        chk("g4_winner", 128'(winner), 128'(1));
        chk("g4_moves", 128'(move_count), 128'(11));
        chk("g4_busy", 128'(bc), 128'(11));
        chk("g4_busy_bound", 128'(bc <= 25), 128'(1));
        chk("g4_board", 128'(board_out), 128'(exp_board));

        // Draw: 42 cells, no run of four.
        pulse_new_game();
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 12; i++) play(2*p + PAIR[i]);
        for (int i = 0; i < 5; i++) play(6);
        chk("g5_not_over", 128'(game_over), 128'(0));
        chk("g5_moves41", 128'(move_count), 128'(41));
        play(6);
        chk("g5_winner", 128'(winner), 128'(3));
        chk("g5_over", 128'(game_over), 128'(1));
        chk("g5_moves", 128'(move_count), 128'(42));
        chk("g5_turn", 128'(turn), 128'(1));
        chk("g5_board", 128'(board_out), 128'(exp_board));

        // new_game mid-CHECK, then coincident with a drop edge, drop held high after.
        pulse_new_game();
        @(negedge clk);
        col_sel = CW'(3);
        drop = 1'b1;
        @(negedge clk);
        drop = 1'b0;
        @(negedge clk);
        model_place(3);
        chk("g6_busy_mid", 128'(busy), 128'(1));
        chk("g6_board_mid", 128'(board_out), 128'(exp_board));
        new_game = 1'b1;
        @(negedge clk);
        model_reset();
        chk("g6_clr_board", 128'(board_out), 128'(0));
        chk("g6_clr_busy", 128'(busy), 128'(0));
        chk("g6_clr_moves", 128'(move_count), 128'(0));
        chk("g6_clr_turn", 128'(turn), 128'(0));
        drop = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        chk("g6_coinc_busy", 128'(busy), 128'(0));
        chk("g6_coinc_board", 128'(board_out), 128'(0));
        repeat (3) @(negedge clk);
        chk("g6_held_moves", 128'(move_count), 128'(0));
        chk("g6_held_busy", 128'(busy), 128'(0));
        drop = 1'b0;
        play(5);
        chk("g6_after_board", 128'(board_out), 128'(exp_board));
        chk("g6_after_moves", 128'(move_count), 128'(1));
        chk("g6_after_busy", 128'(bc), 128'(9));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/connect4_board_engine.md
# connect4_board_engine

Parametrised Connect-4 game engine; generalises the fixed 16-bit board top to any ROWS×COLS board and WIN_LEN run length. Accepts a column select and drop button, places the current player's piece in the lowest free cell, then runs a sequential win/draw scan from the placed cell. Sits between the switch/button front end and the display/pin driver, which consume `board_out` and status outputs.

## Interface
- `COLS`, 7, number of columns (2..16)
- `ROWS`, 6, number of rows (2..16)
- `WIN_LEN`, 4, run length that wins (2..max(ROWS,COLS))
- `CW`, $clog2(COLS), column-select width (derived, not overridden)

- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `col_sel`  in  CW  target column for next drop
- `drop`  in  1  drop request, level (button); rising edge detected internally
- `new_game`  in  1  synchronous clear of game state, level
- `board_out`  out  2*ROWS*COLS  cell (r,c) at bits [2*(r*COLS+c)+:2], r=0 bottom
- `turn`  out  1  0 = player 1 to move, 1 = player 2
- `busy`  out  1  placement/scan in progress
- `invalid`  out  1  one-cycle pulse: rejected drop
- `winner`  out  2  00 none, 01 P1, 10 P2, 11 draw
- `game_over`  out  1  winner != 00
- `move_count`  out  $clog2(ROWS*COLS+1)  pieces placed

## Operation
- Cell encoding: 00 empty, 01 P1, 10 P2. Per-column height counters, 0..ROWS.
- States: IDLE, PLACE, CHECK, DONE.
- IDLE: on `drop` rising edge (drop & ~drop_q), not game_over: if col_sel >= COLS or height[col_sel]==ROWS → `invalid` pulse, stay IDLE, turn unchanged; else latch (row=height, col), → PLACE.
- PLACE (1 cycle): write cell, height++, move_count++, → CHECK with axis=0, dir=+, count=1.
- CHECK: axes order horizontal(0,+1), vertical(+1,0), diagonal(+1,+1), anti-diagonal(+1,-1); each axis walks positive then negative direction. One candidate cell per cycle at offset k=1..WIN_LEN-1. Direction ends on candidate out of bounds, candidate != current player, or k==WIN_LEN-1 evaluated. Match → count++. count reaches WIN_LEN → winner=player, → DONE immediately. Axis finished: reset count=1, next axis. All axes done with no win: move_count==ROWS*COLS → winner=11, DONE; else toggle turn, → IDLE.
- DONE: game_over=1; drops ignored (no invalid pulse); only new_game or reset leaves.
- Drop edges during PLACE/CHECK discarded, not queued; drop_q still tracks.
- new_game: highest priority in any state; next cycle board, heights, move_count, winner, turn cleared, state IDLE. Simultaneous new_game and drop: clear only.
- Arithmetic: row/col offsets computed signed, width CW+1 / RW+1; bounds check before indexing.

## Timing
- Reset (rst_n=0 at edge): board_out=0, turn=0, busy=0, invalid=0, winner=00, game_over=0, move_count=0, drop_q=0, state IDLE.
- Drop edge sampled at cycle N → board_out updated end of N+1 (PLACE); busy high N+1 through last CHECK cycle.
- CHECK length: 1..8*(WIN_LEN-1) cycles; default worst case 24. Total drop-to-ready ≤ 2+8*(WIN_LEN-1).
- `invalid` asserted exactly the cycle after the rejected edge, one cycle.
- winner/game_over registered, valid the cycle after the decisive CHECK cycle; turn toggles same cycle busy falls.

## Structure
- Package `connect4_pkg`: cell encoding constants (CELL_EMPTY/P1/P2), winner codes, state enum, axis delta constants.
- Sub-module `connect4_win_scan`: CHECK walker; inputs board, origin (row,col), player, start; outputs done, win; engine owns board, heights, turn, status.

## Test plan
- Reset then 4 drops alternating col 0/1 by P1 on col 0: after 7th move (P1 4th in col 0) winner=01, game_over=1, move_count=7.
- Horizontal win P2 across cols 3..6 with P1 stacking col 0: winner=10; drop after game_over → no board change, invalid=0.
- Fill col 2 with 6 pieces, 7th drop on col 2 → invalid one-cycle pulse, turn and move_count unchanged; col_sel=7 → invalid.
- Anti-diagonal win completed at middle cell (not end) → win found via negative-direction walk; check busy ≤ 24 cycles.
- Draw sequence filling 42 cells with no run → winner=11 after 42nd move.
- new_game asserted mid-CHECK and coincident with drop → next cycle board_out=0, state IDLE, turn=0; held drop high through reset → no placement without new edge.
